// File: rtl/cnn_mem_loader.sv
// Streams length words from a valid/ready port into consecutive CNN memory writes starting at base_addr.
// Latency: one registered cycle from an accepted beat to its memory write; in_ready is high only in LOAD.
// Optional running checksum output is built when CNN_LOADER_CHECKSUM_EN is defined.
module cnn_mem_loader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_write_enable,
    output logic              busy,
    output logic              done,
`ifdef CNN_LOADER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic              wrap_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   ADDR_SPAN = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, len_q, count_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                wr_en_q;
    logic                done_q;
    logic                wrap_q;
`ifdef CNN_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   csum_q;
`endif

    logic                start_ok;
    logic                accept;
    logic                last_beat;
    logic                ready_c;
    logic [ADDR_W:0]     end_sum;

    assign end_sum = {1'b0, base_addr} + {1'b0, length};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort drops in_ready so a beat offered alongside it is never consumed.
    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        accept    = 1'b0;
        last_beat = 1'b0;
        ready_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    if (length != '0) begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    ready_c = 1'b1;
                    if (in_valid) begin
                        accept = 1'b1;
                        if (count_q == (len_q - ONE)) begin
                            last_beat = 1'b1;
                            state_d   = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            wr_en_q <= accept;
            done_q  <= (accept && last_beat) || (start_ok && (length == '0));
            if (start_ok) begin
                base_q  <= base_addr;
                len_q   <= length;
                count_q <= '0;
                wrap_q  <= (end_sum > ADDR_SPAN);
            end
            if (accept) begin
                addr_q  <= base_q + count_q;
                data_q  <= in_data;
                count_q <= count_q + ONE;
            end
        end
    end

`ifdef CNN_LOADER_CHECKSUM_EN
    // Sum advances on the accept edge so it lines up with the matching write cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
        end else if (start_ok) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_q + in_data;
        end
    end

    assign checksum = csum_q;
`endif

    assign in_ready         = ready_c;
    assign mem_address      = addr_q;
    assign mem_data         = data_q;
    assign mem_write_enable = wr_en_q;
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign wrap_err         = wrap_q;

endmodule

// File: tb/tb_cnn_mem_loader.sv
// Directed bench for cnn_mem_loader: basic, bubble, empty, wrap, abort, reset and checksum loads.
// A small memory model and a write monitor capture what the loader emits.
module tb_cnn_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mem_address;
    logic [15:0] mem_data;
    logic        mem_write_enable;
    logic        busy;
    logic        done;
    logic        wrap_err;
`ifdef CNN_LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] wa[$];
    logic [15:0] wd[$];
    int          done_cnt = 0;
    logic [15:0] tb_mem [0:65535];

    always #5 clk = ~clk;

    cnn_mem_loader #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .base_addr        (base_addr),
        .length           (length),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .mem_address      (mem_address),
        .mem_data         (mem_data),
        .mem_write_enable (mem_write_enable),
        .busy             (busy),
        .done             (done),
`ifdef CNN_LOADER_CHECKSUM_EN
        .checksum         (checksum),
`endif
        .wrap_err         (wrap_err)
    );

    always @(posedge clk) begin
        if (mem_write_enable) tb_mem[mem_address] <= mem_data;
    end

    always @(negedge clk) begin
        if (mem_write_enable) begin
            wa.push_back(mem_address);
            wd.push_back(mem_data);
        end
        if (done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        done_cnt = 0;
    endtask

    initial begin
        logic [399:0] got_vec;
        logic [399:0] exp_vec;
        int           bad;
        int           k;
        int           pat [7] = '{1, 0, 0, 1, 1, 0, 1};

        rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
        in_data = '0; in_valid = 1'b0;
        step(); step();

        // Reset state
        chk("rst_ctrl", {in_ready, mem_write_enable, busy, done, wrap_err}, 5'b0);
        chk("rst_addr", mem_address, 16'h0000);
        chk("rst_data", mem_data, 16'h0000);
        rst = 1'b0;
        step();

        // Basic 25-word load at 0x0100
        clear_log();
        start = 1'b1; base_addr = 16'h0100; length = 16'd25;
        step();
        start = 1'b0;
        chk("basic_busy", busy, 1'b1);
        chk("basic_ready", in_ready, 1'b1);
        for (int i = 0; i < 25; i++) begin
            in_valid = 1'b1; in_data = 16'(i + 1);
            step();
        end
        in_valid = 1'b0;
        chk("basic_done", {done, mem_write_enable, in_ready, busy}, 4'b1101);
        chk("basic_last_addr", mem_address, 16'h0118);
        chk("basic_last_data", mem_data, 16'd25);
        step();
        chk("basic_after", {busy, done, mem_write_enable}, 3'b000);
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            if (i >= wa.size() || wa[i] !== 16'(16'h0100 + i) || wd[i] !== 16'(i + 1)) bad++;
        end
        chk("basic_nwr", wa.size(), 25);
        chk("basic_seq_bad", bad, 0);
        chk("basic_done_cnt", done_cnt, 1);
        for (int i = 0; i < 25; i++) begin
            got_vec[i*16 +: 16] = tb_mem[16'h0100 + i];
            exp_vec[i*16 +: 16] = 16'(i + 1);
        end
        chk("basic_mem_read", got_vec, exp_vec);

        // Bubbles on in_valid
        clear_log();
        start = 1'b1; base_addr = 16'h0010; length = 16'd4;
        step();
        start = 1'b0;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i][0];
            in_data  = 16'(16'h00A0 + k);
            if (pat[i] == 1) k++;
            step();
            chk($sformatf("bub_we_%0d", i), mem_write_enable, pat[i][0]);
            chk($sformatf("bub_done_%0d", i), done, (i == 6));
        end
        in_valid = 1'b0;
        chk("bub_last_addr", mem_address, 16'h0013);
        step();
        chk("bub_nwr", wa.size(), 4);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (i >= wa.size() || wa[i] !== 16'(16'h0010 + i) || wd[i] !== 16'(16'h00A0 + i)) bad++;
        end
        chk("bub_seq_bad", bad, 0);

        // Zero-length load
        clear_log();
        start = 1'b1; base_addr = 16'h0055; length = 16'd0;
        step();
        start = 1'b0;
        chk("zero_done", {done, busy, mem_write_enable, in_ready}, 4'b1000);
        step();
        chk("zero_after", {done, busy}, 2'b00);
        chk("zero_nwr", wa.size(), 0);

        // Wrap past 0xFFFF
        clear_log();
        start = 1'b1; base_addr = 16'hFFFE; length = 16'd4;
        step();
        start = 1'b0;
        chk("wrap_err_set", wrap_err, 1'b1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 16'(16'h0011 + i);
            step();
        end
        in_valid = 1'b0;
        chk("wrap_done", {done, mem_address}, {1'b1, 16'h0001});
        step();
        chk("wrap_addrs", {wa.size() == 4 ? {wa[0], wa[1], wa[2], wa[3]} : 64'h0},
            64'hFFFE_FFFF_0000_0001);
        chk("wrap_sticky", wrap_err, 1'b1);

        // Abort after 10 of 25 beats
        clear_log();
        start = 1'b1; base_addr = 16'h0200; length = 16'd25;
        step();
        start = 1'b0;
        chk("abort_wrap_clr", wrap_err, 1'b0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 16'(16'h0300 + i);
            step();
        end
        abort = 1'b1; in_data = 16'h00EE;
        step();
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_idle", {busy, mem_write_enable, done}, 3'b000);
        step(); step();
        chk("abort_nwr", wa.size(), 10);
        chk("abort_last", (wa.size() == 10) ? {wa[9], wd[9]} : 32'h0, {16'h0209, 16'h0309});
        chk("abort_no_done", done_cnt, 0);

        // Reset in the middle of a load, then a normal load
        clear_log();
        start = 1'b1; base_addr = 16'h0300; length = 16'd25;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 16'(16'h0050 + i);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("mrst_ctrl", {in_ready, mem_write_enable, busy, done, wrap_err}, 5'b0);
        chk("mrst_addr_data", {mem_address, mem_data}, 32'h0);
        clear_log();
        start = 1'b1; base_addr = 16'h0040; length = 16'd2;
        step();
        start = 1'b0;
        in_valid = 1'b1; in_data = 16'h0007;
        step();
        in_data = 16'h0008;
        step();
        in_valid = 1'b0;
        chk("post_rst_done", {done, mem_write_enable, mem_address, mem_data},
            {2'b11, 16'h0041, 16'h0008});
        step();
        chk("post_rst_nwr", wa.size(), 2);
        chk("post_rst_done_cnt", done_cnt, 1);

`ifdef CNN_LOADER_CHECKSUM_EN
        // Running checksum wraps mod 2^16
        start = 1'b1; base_addr = 16'h0000; length = 16'd3;
        step();
        start = 1'b0;
        chk("csum_clear", checksum, 16'h0000);
        in_valid = 1'b1; in_data = 16'hFFFF; step();
        in_data = 16'h0002; step();
        in_data = 16'h0010; step();
        in_valid = 1'b0;
        chk("csum_done", {done, checksum}, {1'b1, 16'h0011});
        step();
        chk("csum_hold", checksum, 16'h0011);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
